gpioemu_mulacc: RTL and testbench
=================================

# gpioemu_mulacc

Parametrised second-generation arithmetic peripheral for the GPIO emulator bus. It computes A1×A2 with a sequential one-bit-per-cycle shift-add engine, with optional accumulate into the result. It also computes the population count of the result and reports ready, valid and overflow status. The host sees it through the same saddress/srd/swr register window as the first-generation block, and gpio_out exposes a completed-operation counter.

## Interface
- ARG_W, 24, operand width in bits (A1, A2); 2 ≤ ARG_W ≤ 32
- RES_W, 32, result register width (W); RES_W ≤ 32
- BASE_ADDR, 16'h0380, base of the 0x28-byte register window
- CNT_W, 16, operation counter width; CNT_W ≤ 32
- clk  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous active-low reset
- saddress  in  16  host register address
- srd  in  1  host read strobe, level, synchronous to clk
- swr  in  1  host write strobe, level, synchronous to clk
- sdata_in  in  32  host write data
- sdata_out  out  32  registered host read data
- gpio_in  in  32  external inputs
- gpio_latch  in  1  gpio_in capture enable
- gpio_in_s_insp  out  32  captured gpio_in
- gpio_out  out  32  {zeros, op_count[CNT_W-1:0]}

## Operation
- Register map, as offsets from BASE_ADDR:
  - +0x00 A1: read/write, low ARG_W bits of sdata_in.
  - +0x08 A2: read/write.
  - +0x10 W: read-only.
  - +0x18 L: read-only, popcount.
  - +0x20 CTRL/STAT.
- CTRL/STAT write:
  - bit0 = start.
  - bit1 = acc: 0 means W := A1×A2; 1 means W := W + A1×A2.
- CTRL/STAT read: {28'b0, acc, overflow, ready, valid}.
- Access detection:
  - A write is the clk edge where swr=1 and swr was 0 on the previous clk.
  - A read is the same condition on srd.
  - Holding a strobe high produces exactly one access.
- Unmapped read returns 0. Unmapped write, or a write to W or L, is ignored.
- FSM states: IDLE, MULT, POP, DONE.
- IDLE → MULT on start:
  - Latch operand copies.
  - Clear the product accumulator P, which is 2·ARG_W+1 bits wide.
  - Set ready=0, valid=1, overflow=0, and store the acc bit.
- MULT runs exactly ARG_W cycles. In cycle i: if A2[i], P += A1<<i.
- MULT → POP:
  - If acc=1, first add W (zero-extended) to P.
  - W := P[RES_W-1:0].
  - overflow := |P[top:RES_W].
  - valid := ~overflow.
- POP: L := popcount(W), which is at most RES_W and fits in 6 bits.
- DONE:
  - ready=1.
  - op_count += 1, wrapping modulo 2^CNT_W.
  - Go to IDLE.
- While busy (ready=0):
  - Writes to A1, A2 and CTRL are ignored; a start during busy is dropped and not queued.
  - Reads are serviced normally; W and L read their previous values.
- gpio_latch=1 at a clk edge: gpio_in_s_insp := gpio_in. Otherwise it holds.
- Reset (asynchronous, any state, including mid-MULT):
  - FSM → IDLE; the operation is abandoned and not counted.
  - A1, A2, W, L, P, op_count := 0.
  - ready=1, valid=1, overflow=0, acc=0.
  - Outputs: sdata_out=0, gpio_out=0, gpio_in_s_insp=0.

## Timing
- Write effect: the register updates at the detecting edge and is visible to a read detected on the next edge.
- Read: sdata_out is updated at the detecting edge and holds until the next read or reset.
- Start latency: the start is detected at edge E0.
  - MULT spans edges E1…E_ARG_W.
  - W, valid and overflow update at E_{ARG_W}.
  - L updates at E_{ARG_W+1}.
  - ready=1 and op_count increment at E_{ARG_W+2}.
- A start written at the same edge ready returns to 1 is accepted only if detected in IDLE, i.e. one edge later.
- A single edge carrying both a write detect and a read detect performs both. The read returns the pre-write value.

## Test plan
- Basic product, ARG_W=24:
  - Stimulus: A1=3, A2=5, CTRL=1, poll STAT.
  - Required: STAT=0b0011 reached 26 edges after detect; W=15; L=4; gpio_out=1.
- Overflow:
  - Stimulus: A1=A2=0xFFFFFF, start.
  - Required: W=0xFE000001; L=8; STAT=0b0110 (overflow=1, ready=1, valid=0).
- Accumulate:
  - Stimulus: after the W=15 case, A1=2, A2=2, CTRL=0b11.
  - Required: W=19; L=3; STAT=0b1011; gpio_out=2.
- Busy rejection:
  - Stimulus: start A1=3, A2=5; during MULT write A1=7 and CTRL=1.
  - Required: W=15; A1 reads 3; op_count advances by exactly 1.
- Reset mid-operation:
  - Stimulus: assert n_reset low at the 10th MULT cycle.
  - Required: immediately all outputs 0; after release STAT=0b0011, W=0, gpio_out=0.
- Counter wrap and gpio latch, CNT_W=2:
  - Stimulus: run 4 operations.
  - Required: gpio_out=0.
  - Stimulus: gpio_in=0xA5A5A5A5 with gpio_latch pulsed, then gpio_in changed.
  - Required: gpio_in_s_insp stays 0xA5A5A5A5.

Source files
------------

// File: rtl/gpioemu_mulacc.sv
// gpioemu_mulacc: bus-mapped sequential multiply-accumulate peripheral.
// A1*A2 is formed one multiplier bit per cycle, optionally added to W, then the
// popcount of W is captured in L. gpio_out shows a wrapping completed-op counter.
module gpioemu_mulacc #(
  parameter int unsigned ARG_W     = 24,
  parameter int unsigned RES_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  // Product accumulator width, and a sum width wide enough for P + W with carry.
  localparam int unsigned PW = 2 * ARG_W + 1;
  localparam int unsigned EW = ((PW > RES_W) ? PW : RES_W) + 1;
  localparam int unsigned IW = $clog2(ARG_W);

  localparam logic [15:0] AddrA1   = BASE_ADDR;
  localparam logic [15:0] AddrA2   = BASE_ADDR + 16'h0008;
  localparam logic [15:0] AddrW    = BASE_ADDR + 16'h0010;
  localparam logic [15:0] AddrL    = BASE_ADDR + 16'h0018;
  localparam logic [15:0] AddrCtrl = BASE_ADDR + 16'h0020;

  typedef enum logic [1:0] {StIdle, StMult, StPop, StDone} state_e;

  state_e             state_q, state_d;
  logic               swr_q, srd_q;
  logic [ARG_W-1:0]   a1_q, a1_d, a2_q, a2_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [ARG_W-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      p_q, p_d;
  logic [IW-1:0]      bit_q, bit_d;
  logic [RES_W-1:0]   w_q, w_d;
  logic [5:0]         l_q, l_d;
  logic               ready_q, ready_d, valid_q, valid_d, ovf_q, ovf_d, acc_q, acc_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [31:0]        sdata_out_q, sdata_out_d;
  logic [31:0]        insp_q, insp_d;

  logic               wr_det, rd_det, idle, start;
  logic [PW-1:0]      p_next;
  logic [EW-1:0]      sum;
  logic               sum_ovf;
  logic [5:0]         pop;
  logic [31:0]        rd_data;
  logic               unused_sdata;

  // Rising-edge detect on the level strobes: one access per assertion.
  assign wr_det = swr & ~swr_q;
  assign rd_det = srd & ~srd_q;
  assign idle   = (state_q == StIdle);
  assign start  = wr_det & idle & (saddress == AddrCtrl) & sdata_in[0];
  assign unused_sdata = ^sdata_in;

  // Datapath: one shift-add step, final accumulate/overflow, popcount of W.
  always_comb begin
    p_next  = p_q + (mplier_q[0] ? mcand_q : '0);
    sum     = EW'(p_next) + (acc_q ? EW'(w_q) : '0);
    sum_ovf = (sum >> RES_W) != '0;
    pop     = '0;
    for (int i = 0; i < int'(RES_W); i++) begin
      pop = pop + 6'(w_q[i]);
    end
  end

  // Host read mux; sampled into sdata_out only on a detected read.
  always_comb begin
    rd_data = '0;
    unique case (saddress)
      AddrA1:   rd_data = 32'(a1_q);
      AddrA2:   rd_data = 32'(a2_q);
      AddrW:    rd_data = 32'(w_q);
      AddrL:    rd_data = 32'(l_q);
      AddrCtrl: rd_data = {28'b0, acc_q, ovf_q, ready_q, valid_q};
      default:  rd_data = '0;
    endcase
  end

  // Next-state: register writes, FSM sequencing and status updates.
  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    p_d         = p_q;
    bit_d       = bit_q;
    w_d         = w_q;
    l_d         = l_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    op_cnt_d    = op_cnt_q;
    sdata_out_d = rd_det ? rd_data : sdata_out_q;
    insp_d      = gpio_latch ? gpio_in : insp_q;

    // Operand writes are only accepted while idle.
    if (wr_det && idle) begin
      if (saddress == AddrA1) a1_d = sdata_in[ARG_W-1:0];
      if (saddress == AddrA2) a2_d = sdata_in[ARG_W-1:0];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = PW'(a1_q);
          mplier_d = a2_q;
          p_d      = '0;
          bit_d    = '0;
          ready_d  = 1'b0;
          valid_d  = 1'b1;
          ovf_d    = 1'b0;
          acc_d    = sdata_in[1];
          state_d  = StMult;
        end
      end
      StMult: begin
        p_d      = p_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d    = bit_q + IW'(1);
        // Last partial product folds straight into W on the same edge.
        if (bit_q == IW'(ARG_W - 1)) begin
          w_d     = sum[RES_W-1:0];
          ovf_d   = sum_ovf;
          valid_d = ~sum_ovf;
          state_d = StPop;
        end
      end
      StPop: begin
        l_d     = pop;
        state_d = StDone;
      end
      StDone: begin
        ready_d  = 1'b1;
        op_cnt_d = op_cnt_q + CNT_W'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      p_q         <= '0;
      bit_q       <= '0;
      w_q         <= '0;
      l_q         <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b1;
      ovf_q       <= 1'b0;
      acc_q       <= 1'b0;
      op_cnt_q    <= '0;
      sdata_out_q <= '0;
      insp_q      <= '0;
    end else begin
      state_q     <= state_d;
      swr_q       <= swr;
      srd_q       <= srd;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      p_q         <= p_d;
      bit_q       <= bit_d;
      w_q         <= w_d;
      l_q         <= l_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      op_cnt_q    <= op_cnt_d;
      sdata_out_q <= sdata_out_d;
      insp_q      <= insp_d;
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_in_s_insp = insp_q;
  assign gpio_out       = 32'(op_cnt_q);

endmodule

// File: tb/tb_gpioemu_mulacc.sv
// Directed bench for gpioemu_mulacc: a default instance plus a CNT_W=2 instance
// sharing the same bus, so the counter wrap is observed on the second one.
module tb_gpioemu_mulacc;

  localparam logic [15:0] Base = 16'h0380;
  localparam logic [15:0] RegA1 = Base + 16'h00;
  localparam logic [15:0] RegA2 = Base + 16'h08;
  localparam logic [15:0] RegW  = Base + 16'h10;
  localparam logic [15:0] RegL  = Base + 16'h18;
  localparam logic [15:0] RegCs = Base + 16'h20;

  logic        clk, n_reset, srd, swr, gpio_latch;
  logic [15:0] saddress;
  logic [31:0] sdata_in, gpio_in;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;
  logic [31:0] sdata_out2, gpio_in_s_insp2, gpio_out2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;

  gpioemu_mulacc u_dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .saddress      (saddress),
    .srd           (srd),
    .swr           (swr),
    .sdata_in      (sdata_in),
    .sdata_out     (sdata_out),
    .gpio_in       (gpio_in),
    .gpio_latch    (gpio_latch),
    .gpio_in_s_insp(gpio_in_s_insp),
    .gpio_out      (gpio_out)
  );

  gpioemu_mulacc #(.CNT_W(2)) u_dut_c2 (
    .clk           (clk),
    .n_reset       (n_reset),
    .saddress      (saddress),
    .srd           (srd),
    .swr           (swr),
    .sdata_in      (sdata_in),
    .sdata_out     (sdata_out2),
    .gpio_in       (gpio_in),
    .gpio_latch    (gpio_latch),
    .gpio_in_s_insp(gpio_in_s_insp2),
    .gpio_out      (gpio_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe held for one cycle; the access is detected at the edge in between.
  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    sdata_in = data;
    swr      = 1'b1;
    @(negedge clk);
    swr      = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    srd      = 1'b1;
    @(negedge clk);
    srd      = 1'b0;
    data     = sdata_out;
  endtask

  task automatic start_op(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] ctrl);
    bus_write(RegA1, a1);
    bus_write(RegA2, a2);
    bus_write(RegCs, ctrl);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_read(RegCs, s);
      if (s[1]) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    n_reset = 1'b0; srd = 1'b0; swr = 1'b0; gpio_latch = 1'b0;
    saddress = '0; sdata_in = '0; gpio_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_sdata_out", sdata_out, 32'h0);
    check_eq("rst_gpio_out", gpio_out, 32'h0);
    check_eq("rst_insp", gpio_in_s_insp, 32'h0);
    n_reset = 1'b1;
    bus_read(RegCs, rd);
    check_eq("rst_stat", rd, 32'h3);

    // Basic product with exact completion edge (E26 after detect)
    start_op(32'd3, 32'd5, 32'h1);
    repeat (25) @(negedge clk);
    check_eq("basic_cnt_e25", gpio_out, 32'd0);
    @(negedge clk);
    check_eq("basic_cnt_e26", gpio_out, 32'd1);
    bus_read(RegCs, rd); check_eq("basic_stat", rd, 32'h3);
    bus_read(RegW, rd);  check_eq("basic_w", rd, 32'd15);
    bus_read(RegL, rd);  check_eq("basic_l", rd, 32'd4);

    // Accumulate onto W=15
    start_op(32'd2, 32'd2, 32'h3);
    wait_done();
    bus_read(RegW, rd);  check_eq("acc_w", rd, 32'd19);
    bus_read(RegL, rd);  check_eq("acc_l", rd, 32'd3);
    bus_read(RegCs, rd); check_eq("acc_stat", rd, 32'hB);
    check_eq("acc_cnt", gpio_out, 32'd2);

    // Overflow; write of all ones is truncated to 24 bits
    start_op(32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h1);
    wait_done();
    bus_read(RegW, rd);  check_eq("ovf_w", rd, 32'hFE00_0001);
    bus_read(RegL, rd);  check_eq("ovf_l", rd, 32'd8);
    bus_read(RegCs, rd); check_eq("ovf_stat", rd, 32'h6);
    bus_read(RegA1, rd); check_eq("ovf_a1_mask", rd, 32'h00FF_FFFF);
    check_eq("c2_cnt3", gpio_out2, 32'd3);

    // Busy rejection: A1 write and second start during MULT are dropped
    start_op(32'd3, 32'd5, 32'h1);
    bus_write(RegA1, 32'd7);
    bus_write(RegCs, 32'h1);
    wait_done();
    bus_read(RegW, rd);  check_eq("busy_w", rd, 32'd15);
    bus_read(RegA1, rd); check_eq("busy_a1", rd, 32'd3);
    repeat (30) @(negedge clk);
    check_eq("busy_cnt", gpio_out, 32'd4);
    bus_read(RegCs, rd); check_eq("busy_stat", rd, 32'h3);
    check_eq("c2_wrap", gpio_out2, 32'd0);

    // Unmapped read and read-only write
    bus_read(Base + 16'h0004, rd); check_eq("unmapped_rd", rd, 32'h0);
    bus_write(RegW, 32'h1234);
    bus_read(RegW, rd); check_eq("w_readonly", rd, 32'd15);

    // gpio capture holds after latch drops
    @(negedge clk);
    gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check_eq("latch_hold", gpio_in_s_insp, 32'hA5A5_A5A5);
    check_eq("latch_hold_c2", gpio_in_s_insp2, 32'hA5A5_A5A5);

    // Reset asserted just before the 10th MULT edge
    bus_read(RegCs, rd);
    start_op(32'd3, 32'd5, 32'h1);
    repeat (9) @(negedge clk);
    n_reset = 1'b0;
    #1;
    check_eq("mid_rst_sdata_out", sdata_out, 32'h0);
    check_eq("mid_rst_gpio_out", gpio_out, 32'h0);
    check_eq("mid_rst_insp", gpio_in_s_insp, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    bus_read(RegCs, rd); check_eq("post_rst_stat", rd, 32'h3);
    bus_read(RegW, rd);  check_eq("post_rst_w", rd, 32'h0);
    bus_read(RegA1, rd); check_eq("post_rst_a1", rd, 32'h0);
    repeat (30) @(negedge clk);
    check_eq("post_rst_cnt", gpio_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
